// File: rtl/hazard_pkg.sv
// hazard_pkg: shared widths, Tnew/Tuse codes, forwarding encodings and scoreboard entry layouts
package hazard_pkg;
  localparam int AW = 5;
  localparam int TW = 2;
  localparam logic [TW-1:0] TUSE_NONE = 2'd3;
  localparam logic [TW-1:0] TNEW_JAL = 2'd0;
  localparam logic [TW-1:0] TNEW_ALU = 2'd1;
  localparam logic [TW-1:0] TNEW_LW = 2'd2;
  localparam logic [1:0] FWD_D_RF = 2'd0;
  localparam logic [1:0] FWD_D_E = 2'd1;
  localparam logic [1:0] FWD_D_M = 2'd2;
  localparam logic [1:0] FWD_D_W = 2'd3;
  localparam logic [1:0] FWD_E_PIPE = 2'd0;
  localparam logic [1:0] FWD_E_M = 2'd1;
  localparam logic [1:0] FWD_E_W = 2'd2;
  typedef struct packed {
    logic [AW-1:0] dst;
    logic [TW-1:0] tnew;
  } slot_t;
  typedef struct packed {
    logic [AW-1:0] dst;
    logic [TW-1:0] tnew;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
  } entry_t;
  localparam int SW = $bits(slot_t);
  localparam int EW = $bits(entry_t);
  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
    return t == '0 ? t : t - 1'b1;
  endfunction
endpackage

// File: rtl/sb_entry.sv
// sb_entry: one scoreboard slot {dst, tnew, [rs, rt]} with bubble load and optional tnew countdown
module sb_entry
  import hazard_pkg::*;
#(
  parameter int W = SW,
  parameter bit DEC = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         bubble_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  localparam int TL = W - AW - TW;
  logic [W-1:0] q_d, q_q;
  always_comb begin
    q_d = bubble_i ? '0 : d_i;
    if (DEC) q_d[TL +: TW] = sat_dec(q_d[TL +: TW]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= '0;
    else q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight writes across E/M/W and derives the D-stage stall
// plus operand-forwarding selects for the D and E stages.
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] d_rs_i,
  input  logic [AW-1:0] d_rt_i,
  input  logic [TW-1:0] d_tuse_rs_i,
  input  logic [TW-1:0] d_tuse_rt_i,
  input  logic [AW-1:0] d_dst_i,
  input  logic [TW-1:0] d_tnew_i,
  input  logic          flush_e_i,
  output logic          stall_o,
  output logic [1:0]    fwd_rs_d_o,
  output logic [1:0]    fwd_rt_d_o,
  output logic [1:0]    fwd_rs_e_o,
  output logic [1:0]    fwd_rt_e_o
);
  entry_t e_d, e_q;
  slot_t  e_s, m_q, w_q;
  function automatic logic hit(input logic [AW-1:0] a, input slot_t s);
    return a != '0 && s.dst == a;
  endfunction
  // only the youngest producer of a register decides whether the reader must wait
  function automatic logic hazard(input logic [AW-1:0] a, input logic [TW-1:0] tuse,
                                  input slot_t e, input slot_t m, input slot_t w);
    slot_t y;
    y = hit(a, e) ? e : hit(a, m) ? m : w;
    return tuse != TUSE_NONE && hit(a, y) && y.tnew > tuse;
  endfunction
  function automatic logic [1:0] fwd_d(input logic [AW-1:0] a, input slot_t e,
                                       input slot_t m, input slot_t w);
    return hit(a, e) ? (e.tnew == '0 ? FWD_D_E : FWD_D_RF) :
           hit(a, m) ? (m.tnew == '0 ? FWD_D_M : FWD_D_RF) :
           hit(a, w) && w.tnew == '0 ? FWD_D_W : FWD_D_RF;
  endfunction
  function automatic logic [1:0] fwd_e(input logic [AW-1:0] a, input slot_t m, input slot_t w);
    return hit(a, m) ? (m.tnew == '0 ? FWD_E_M : FWD_E_PIPE) :
           hit(a, w) && w.tnew == '0 ? FWD_E_W : FWD_E_PIPE;
  endfunction
  assign e_d = '{dst: d_dst_i, tnew: d_tnew_i, rs: d_rs_i, rt: d_rt_i};
  assign e_s = '{dst: e_q.dst, tnew: e_q.tnew};
  sb_entry #(.W(EW), .DEC(1'b0)) u_e (
    .clk(clk), .rst_n(rst_n), .bubble_i(stall_o | flush_e_i), .d_i(e_d), .q_o(e_q)
  );
  sb_entry #(.W(SW), .DEC(1'b1)) u_m (
    .clk(clk), .rst_n(rst_n), .bubble_i(1'b0), .d_i(e_s), .q_o(m_q)
  );
  sb_entry #(.W(SW), .DEC(1'b1)) u_w (
    .clk(clk), .rst_n(rst_n), .bubble_i(1'b0), .d_i(m_q), .q_o(w_q)
  );
  assign stall_o = hazard(d_rs_i, d_tuse_rs_i, e_s, m_q, w_q) |
                   hazard(d_rt_i, d_tuse_rt_i, e_s, m_q, w_q);
  assign fwd_rs_d_o = fwd_d(d_rs_i, e_s, m_q, w_q);
  assign fwd_rt_d_o = fwd_d(d_rt_i, e_s, m_q, w_q);
  assign fwd_rs_e_o = fwd_e(e_q.rs, m_q, w_q);
  assign fwd_rt_e_o = fwd_e(e_q.rt, m_q, w_q);
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed pipeline scenarios plus random traffic checked against
// an age-based model of the instructions in flight.
module tb_hazard_scoreboard;
  import hazard_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [AW-1:0] d_rs = '0, d_rt = '0, d_dst = '0;
  logic [TW-1:0] d_tuse_rs = '0, d_tuse_rt = '0, d_tnew = '0;
  logic flush_e = 1'b0;
  logic stall;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
  int checks = 0, errors = 0;
  typedef struct { int dst; int tnew; int rs; int rt; } ins_t;
  ins_t pipe [3];

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .d_rs_i(d_rs), .d_rt_i(d_rt), .d_tuse_rs_i(d_tuse_rs),
    .d_tuse_rt_i(d_tuse_rt), .d_dst_i(d_dst), .d_tnew_i(d_tnew), .flush_e_i(flush_e),
    .stall_o(stall), .fwd_rs_d_o(fwd_rs_d), .fwd_rt_d_o(fwd_rt_d),
    .fwd_rs_e_o(fwd_rs_e), .fwd_rt_e_o(fwd_rt_e)
  );

  always #5 clk = ~clk;

  // cycles still needed before the instruction at pipeline age k has its result
  function automatic int rem(int k);
    return pipe[k].tnew > k ? pipe[k].tnew - k : 0;
  endfunction
  function automatic int young(int a, int from);
    int r;
    r = -1;
    for (int k = 2; k >= from; k--) if (a != 0 && pipe[k].dst == a) r = k;
    return r;
  endfunction
  function automatic logic hz(int a, int tuse);
    int k;
    k = young(a, 0);
    return tuse != 3 && k >= 0 && rem(k) > tuse;
  endfunction
  function automatic logic [1:0] fd(int a);
    int k;
    k = young(a, 0);
    return (k < 0 || rem(k) != 0) ? 2'd0 : 2'(k + 1);
  endfunction
  function automatic logic [1:0] fe(int a);
    int k;
    k = young(a, 1);
    return (k < 0 || rem(k) != 0) ? 2'd0 : 2'(k);
  endfunction

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 3; k++) pipe[k] = ins_t'{0, 0, 0, 0};
  endtask

  task automatic drive(input int rs, input int rt, input int tr, input int tt,
                       input int dst, input int tn, input bit fl);
    d_rs = AW'(rs); d_rt = AW'(rt); d_tuse_rs = TW'(tr); d_tuse_rt = TW'(tt);
    d_dst = AW'(dst); d_tnew = TW'(tn); flush_e = fl;
    #4;
    chk("stall", {1'b0, stall}, {1'b0, hz(rs, tr) | hz(rt, tt)});
    chk("fwd_rs_d", fwd_rs_d, fd(rs));
    chk("fwd_rt_d", fwd_rt_d, fd(rt));
    chk("fwd_rs_e", fwd_rs_e, fe(pipe[0].rs));
    chk("fwd_rt_e", fwd_rt_e, fe(pipe[0].rt));
  endtask

  task automatic tick();
    logic s;
    s = hz(int'(d_rs), int'(d_tuse_rs)) | hz(int'(d_rt), int'(d_tuse_rt));
    @(posedge clk);
    for (int k = 2; k > 0; k--) pipe[k] = pipe[k-1];
    pipe[0] = (s || flush_e) ? ins_t'{0, 0, 0, 0} :
              ins_t'{int'(d_dst), int'(d_tnew), int'(d_rs), int'(d_rt)};
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, {1'b0, stall}, 2'd0);
    chk({tag, "_rs_d"}, fwd_rs_d, 2'd0);
    chk({tag, "_rt_d"}, fwd_rt_d, 2'd0);
    chk({tag, "_rs_e"}, fwd_rs_e, 2'd0);
    chk({tag, "_rt_e"}, fwd_rt_e, 2'd0);
  endtask

  initial begin
    clear_model();
    #2;
    chk_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    // lw $8 then beq $8: two stall cycles, then the load is taken from W
    drive(0, 0, 3, 3, 8, int'(TNEW_LW), 0); tick();
    drive(8, 0, 0, 3, 0, 1, 0); chk("t1_stall_a", {1'b0, stall}, 2'd1); tick();
    drive(8, 0, 0, 3, 0, 1, 0); chk("t1_stall_b", {1'b0, stall}, 2'd1); tick();
    drive(8, 0, 0, 3, 0, 1, 0); chk("t1_release", {1'b0, stall}, 2'd0);
    chk("t1_fwd_w", fwd_rs_d, FWD_D_W); tick();
    // add $9 then ori $9 used in E: no stall, forwarded from M in E
    drive(0, 0, 3, 3, 9, int'(TNEW_ALU), 0); tick();
    drive(9, 0, 1, 3, 10, 1, 0); chk("t2_nostall", {1'b0, stall}, 2'd0);
    chk("t2_fwd_d", fwd_rs_d, FWD_D_RF); tick();
    drive(0, 0, 3, 3, 0, 0, 0); chk("t2_fwd_e", fwd_rs_e, FWD_E_M); tick();
    // jal then jr $31
    drive(0, 0, 3, 3, 31, int'(TNEW_JAL), 0); tick();
    drive(31, 0, 0, 3, 0, 0, 0); chk("t3_nostall", {1'b0, stall}, 2'd0);
    chk("t3_fwd_e", fwd_rs_d, FWD_D_E); tick();
    // writes to $0 are never tracked
    drive(0, 0, 3, 3, 0, 2, 0); tick();
    drive(0, 0, 0, 0, 0, 2, 0); chk_all_zero("t4a"); tick();
    drive(0, 0, 0, 0, 0, 0, 0); chk_all_zero("t4b"); tick();
    // two writers of $5: the younger (not ready) hides the older ready one
    drive(0, 0, 3, 3, 5, int'(TNEW_ALU), 0); tick();
    drive(0, 0, 3, 3, 5, int'(TNEW_ALU), 0); tick();
    drive(5, 0, 0, 3, 0, 0, 0); chk("t5_stall", {1'b0, stall}, 2'd1);
    chk("t5_fwd", fwd_rs_d, FWD_D_RF); tick();
    // stall and flush together insert one bubble
    drive(0, 0, 3, 3, 7, int'(TNEW_LW), 0); tick();
    drive(0, 7, 3, 0, 0, 0, 1); chk("t7_stall", {1'b0, stall}, 2'd1); tick();
    drive(0, 7, 3, 0, 0, 0, 0); tick();
    drive(0, 7, 3, 0, 0, 0, 0); chk("t7_fwd", fwd_rt_d, FWD_D_W); tick();
    // asynchronous reset in the middle of a load-use stall
    drive(0, 0, 3, 3, 8, int'(TNEW_LW), 0); tick();
    drive(8, 0, 0, 3, 0, 0, 0); chk("t6_stall", {1'b0, stall}, 2'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t6_async");
    clear_model();
    @(posedge clk);
    #1;
    chk_all_zero("t6_hold");
    rst_n = 1'b1;
    drive(8, 0, 0, 3, 0, 0, 0); chk("t6_after", {1'b0, stall}, 2'd0); tick();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 2),
            $urandom_range(0, 7) == 0);
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
